// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: one 32-bit load/store becomes two timed half-word
// accesses to a 16-bit asynchronous SRAM. Optional read buffer: SRAM_RD_BUF_EN.
module sram_mem_ctrl #(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0]  HOLD_CNT = 4'(WAIT_CYCLES - 2);
    localparam logic [31:0] BASE32   = 32'(BASE_ADDR);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [16:0] r_wa;
    logic [31:0] r_st_val;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic [17:0] r_sram_addr;
    logic [15:0] r_sram_dq_out;
    logic        r_sram_dq_oe;
    logic        r_sram_we_n;
    logic        r_sram_oe_n;

    logic [16:0] w_wa;
    logic        w_hit;

    assign w_wa = 17'((ALU_result - BASE32) >> 2);

`ifdef SRAM_RD_BUF_EN
    logic        r_buf_valid;
    logic [16:0] r_buf_tag;
    logic [31:0] r_buf_data;

    assign w_hit = r_buf_valid && (r_buf_tag == w_wa);
`else
    assign w_hit = 1'b0;
`endif

    // Freeze is combinational so a new request stalls the pipeline in the cycle it appears.
    always_comb begin
        freeze = 1'b0;
        case (r_state)
            S_IDLE:  freeze = (MEM_R_EN | MEM_W_EN) & ~r_ready;
            S_DONE:  freeze = 1'b0;
            default: freeze = 1'b1;
        endcase
    end

    // Access sequencer; every SRAM pin is registered and set up one edge ahead of its phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_wa          <= 17'd0;
            r_st_val      <= 32'd0;
            r_rdata       <= 32'd0;
            r_ready       <= 1'b0;
            r_sram_addr   <= 18'd0;
            r_sram_dq_out <= 16'd0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
`ifdef SRAM_RD_BUF_EN
            r_buf_valid   <= 1'b0;
            r_buf_tag     <= 17'd0;
            r_buf_data    <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= 4'd0;
                    r_ready <= 1'b0;
                    if (MEM_W_EN) begin
                        r_state       <= S_WR_LO;
                        r_wa          <= w_wa;
                        r_st_val      <= ST_val;
                        r_sram_addr   <= {w_wa, 1'b0};
                        r_sram_dq_out <= ST_val[15:0];
                        r_sram_dq_oe  <= 1'b1;
                        r_sram_we_n   <= 1'b0;
`ifdef SRAM_RD_BUF_EN
                        if (w_hit) begin
                            r_buf_data <= ST_val;
                        end
`endif
                    end else if (MEM_R_EN) begin
                        r_wa <= w_wa;
                        if (w_hit) begin
`ifdef SRAM_RD_BUF_EN
                            r_rdata <= r_buf_data;
`endif
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state     <= S_RD_LO;
                            r_sram_addr <= {w_wa, 1'b0};
                            r_sram_oe_n <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_LO: begin
                    if (r_cnt == LAST_CNT) begin
                        r_rdata[15:0] <= SRAM_DQ_in;
                        r_state       <= S_RD_HI;
                        r_cnt         <= 4'd0;
                        r_sram_addr   <= {r_wa, 1'b1};
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RD_HI: begin
                    if (r_cnt == LAST_CNT) begin
                        r_rdata[31:16] <= SRAM_DQ_in;
                        r_state        <= S_DONE;
                        r_cnt          <= 4'd0;
                        r_ready        <= 1'b1;
                        r_sram_oe_n    <= 1'b1;
`ifdef SRAM_RD_BUF_EN
                        r_buf_valid    <= 1'b1;
                        r_buf_tag      <= r_wa;
                        r_buf_data     <= {SRAM_DQ_in, r_rdata[15:0]};
`endif
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WR_LO: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state       <= S_WR_HI;
                        r_cnt         <= 4'd0;
                        r_sram_addr   <= {r_wa, 1'b1};
                        r_sram_dq_out <= r_st_val[31:16];
                        r_sram_we_n   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        // Release the strobe one cycle early so address/data are held past WE rise.
                        if (r_cnt == HOLD_CNT) begin
                            r_sram_we_n <= 1'b1;
                        end
                    end
                end
                S_WR_HI: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state      <= S_DONE;
                        r_cnt        <= 4'd0;
                        r_ready      <= 1'b1;
                        r_sram_dq_oe <= 1'b0;
                        r_sram_we_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == HOLD_CNT) begin
                            r_sram_we_n <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= 4'd0;
                    r_ready      <= 1'b0;
                    r_sram_dq_oe <= 1'b0;
                    r_sram_we_n  <= 1'b1;
                    r_sram_oe_n  <= 1'b1;
                end
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign ready       = r_ready;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_DQ_out = r_sram_dq_out;
    assign SRAM_DQ_oe  = r_sram_dq_oe;
    assign SRAM_WE_N   = r_sram_we_n;
    assign SRAM_OE_N   = r_sram_oe_n;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl with a behavioural 16-bit SRAM model.
module tb_sram_mem_ctrl;

    localparam int W = 3;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_DQ_oe;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;

    int total;
    int bad;

    logic [15:0] mem [256];
    logic [31:0] sb [$];
    logic [31:0] last_rd;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] val;
        logic [31:0] exp;
        int          drop;
    } vec_t;

    vec_t vecs [7];

    sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_result (ALU_result),
        .ST_val     (ST_val),
        .rdata      (rdata),
        .ready      (ready),
        .freeze     (freeze),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_in (SRAM_DQ_in),
        .SRAM_DQ_oe (SRAM_DQ_oe),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: store while strobe is low and pad is driven, read while OE_N is low.
    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) mem[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
    end
    assign SRAM_DQ_in = !SRAM_OE_N ? mem[SRAM_ADDR[7:0]] : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] val, input logic [31:0] exp, input int drop);
        logic [16:0] wa;
        logic        is_wr;
        logic        is_rd;
        logic        done;
        int          ph;
        int          c;
        logic [31:0] got;
        is_wr = we;
        is_rd = !we && re;
        wa    = 17'((addr - 32'd1024) >> 2);
        @(negedge clk);
        MEM_W_EN   = we;
        MEM_R_EN   = re;
        ALU_result = addr;
        ST_val     = val;
        if (is_rd) last_rd = exp;
        sb.push_back(last_rd);
        #1;
        chk("freeze_at_t", {31'd0, freeze}, 32'd1);
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (k <= 2 * W) begin
                ph = (k - 1) / W;
                c  = (k - 1) % W;
                chk("sram_addr", {14'd0, SRAM_ADDR}, {14'd0, wa, ph[0]});
                chk("we_n", {31'd0, SRAM_WE_N}, {31'd0, is_wr ? (c == W - 1) : 1'b1});
                chk("oe_n", {31'd0, SRAM_OE_N}, {31'd0, !is_rd});
                chk("dq_oe", {31'd0, SRAM_DQ_oe}, {31'd0, is_wr});
                if (is_wr) chk("dq_out", {16'd0, SRAM_DQ_out}, {16'd0, (ph == 1) ? val[31:16] : val[15:0]});
                chk("freeze_busy", {31'd0, freeze}, 32'd1);
                chk("ready_busy", {31'd0, ready}, 32'd0);
            end
            if (ready) begin
                chk("latency", k, 2 * W + 1);
                chk("freeze_done", {31'd0, freeze}, 32'd0);
                chk("we_n_done", {31'd0, SRAM_WE_N}, 32'd1);
                chk("dq_oe_done", {31'd0, SRAM_DQ_oe}, 32'd0);
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("rdata", rdata, got);
                end
                done = 1'b1;
            end
            if (k == drop) begin
                MEM_W_EN   = 1'b0;
                MEM_R_EN   = 1'b0;
                ALU_result = 32'hFFFF_FFF0;
                ST_val     = 32'h0BAD_0BAD;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
        end
        MEM_W_EN = 1'b0;
        MEM_R_EN = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        last_rd    = 32'd0;
        rst        = 1'b0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'd0;
        ST_val     = 32'd0;

        vecs[0] = '{we: 1'b1, re: 1'b0, addr: 32'd1028, val: 32'hDEADBEEF, exp: 32'd0,         drop: 99};
        vecs[1] = '{we: 1'b0, re: 1'b1, addr: 32'd1028, val: 32'h0,        exp: 32'hDEADBEEF, drop: 99};
        vecs[2] = '{we: 1'b1, re: 1'b1, addr: 32'd1032, val: 32'h12345678, exp: 32'd0,         drop: 2};
        vecs[3] = '{we: 1'b0, re: 1'b1, addr: 32'd1032, val: 32'h0,        exp: 32'h12345678, drop: 3};
        vecs[4] = '{we: 1'b1, re: 1'b0, addr: 32'd1039, val: 32'hA5A55A5A, exp: 32'd0,         drop: 5};
        vecs[5] = '{we: 1'b0, re: 1'b1, addr: 32'd1036, val: 32'h0,        exp: 32'hA5A55A5A, drop: 99};
        vecs[6] = '{we: 1'b0, re: 1'b1, addr: 32'd1029, val: 32'h0,        exp: 32'hDEADBEEF, drop: 1};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        chk("rst_dq_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].val, vecs[i].exp, vecs[i].drop);
        end

        // Reset in the middle of a store, in the first cycle of the high phase.
        @(negedge clk);
        MEM_W_EN   = 1'b1;
        ALU_result = 32'd1040;
        ST_val     = 32'hCAFEF00D;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_we_n", {31'd0, SRAM_WE_N}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("midrst_dq_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        chk("midrst_freeze_req", {31'd0, freeze}, 32'd1);
        MEM_W_EN = 1'b0;
        #1;
        chk("midrst_freeze_idle", {31'd0, freeze}, 32'd0);
        last_rd = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);

        run_txn(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 99);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Sequences the MEM-stage access issued by the EXE stage register: a load or store to a 32-bit word held in an external 16-bit asynchronous SRAM.
- Splits each word access into two timed half-word phases and reports the result.
- Holds the whole pipeline via freeze until the access completes.
- Sits between the EXE stage register outputs (MEM_R_EN, MEM_W_EN, ALU_result, ST_val) and the SRAM pins. Its rdata feeds the MEM stage register.

Parameters:
- WAIT_CYCLES, 3, clock cycles per half-word phase; legal range 2..15.
- BASE_ADDR, 1024, data-memory base byte address, subtracted before mapping.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEM_R_EN  in  1  load request from EXE stage register.
- MEM_W_EN  in  1  store request from EXE stage register.
- ALU_result  in  32  byte address of the access.
- ST_val  in  32  store data.
- rdata  out  32  load result.
- ready  out  1  access complete this cycle.
- freeze  out  1  stall all pipeline registers and PC.
- SRAM_ADDR  out  18  half-word address.
- SRAM_DQ_out  out  16  write data to pad.
- SRAM_DQ_in  in  16  read data from pad.
- SRAM_DQ_oe  out  1  pad output enable.
- SRAM_WE_N  out  1  SRAM write strobe, active low.
- SRAM_OE_N  out  1  SRAM output enable, active low.

Behaviour:
- Address mapping:
  - wa = (ALU_result - BASE_ADDR) >> 2, 32-bit subtract, upper bits dropped.
  - Low half-word at SRAM_ADDR = {wa[16:0],0}; high half-word at {wa[16:0],1}.
  - ALU_result[1:0] is ignored.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A 4-bit phase counter cnt runs from 0 to WAIT_CYCLES-1.
- IDLE:
  - If MEM_W_EN=1, go to WR_LO. Write has priority when both enables are 1.
  - Else if MEM_R_EN=1, go to RD_LO. Else stay.
  - cnt=0 on entry to any phase.
- Phase progression: each phase lasts exactly WAIT_CYCLES cycles.
  - RD_LO -> RD_HI -> DONE.
  - WR_LO -> WR_HI -> DONE.
  - DONE -> IDLE unconditionally after 1 cycle.
- Address, data and latch timing:
  - SRAM_ADDR holds the phase's half-word address for the whole phase.
  - Address, store data and request type are latched on IDLE exit. Input changes mid-access are ignored.
- Reads:
  - SRAM_OE_N=0 during RD_*. SRAM_DQ_oe=0.
  - SRAM_DQ_in is sampled on the last cycle of RD_LO into rdata[15:0], and on the last cycle of RD_HI into rdata[31:16].
  - rdata holds its value otherwise, including across writes.
- Writes:
  - SRAM_DQ_oe=1 during WR_*.
  - SRAM_DQ_out = ST_val[15:0] in WR_LO, ST_val[31:16] in WR_HI.
  - SRAM_WE_N=0 for cnt 0..WAIT_CYCLES-2 and =1 on the last cycle of each phase, giving an address/data hold cycle.
- Idle outputs: outside WR_*, SRAM_WE_N=1 and SRAM_DQ_oe=0. Outside RD_*, SRAM_OE_N=1.
- ready = 1 only in DONE.
- freeze = (MEM_R_EN | MEM_W_EN) & ~ready in IDLE; freeze = 1 in every RD_*/WR_* state; freeze = 0 in DONE.
- Latency: a request first seen in IDLE at cycle t gives freeze=1 for t..t+2*WAIT_CYCLES and ready=1 at t+2*WAIT_CYCLES+1. The pipeline advances at the end of DONE.
- Back-to-back requests: the next request enters IDLE at t+2*WAIT_CYCLES+2 and is accepted that cycle.
- Request dropped mid-access: the transaction still completes. Stores are never aborted.
- Reset values:
  - rst=0 at any time, including mid-write: state=IDLE, cnt=0, rdata=0, ready=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
  - freeze follows its combinational rule from the IDLE state.

Optional Feature:
- SRAM_RD_BUF_EN defined:
  - Adds a single-entry read buffer with tag = wa[16:0] and a valid bit (valid=0 on reset).
  - A load whose wa matches a valid tag goes IDLE -> DONE directly: rdata = buffered word, ready at t+1, freeze high only at t, no SRAM cycle.
  - A completed read fills the buffer.
  - A write to the tagged word updates the buffer data; a write to any other word leaves it unchanged.
- SRAM_RD_BUF_EN undefined: every load performs the full two-phase SRAM access and no buffer logic exists.

Test Plan:
- Reset then idle, no enables -> freeze=0, SRAM_WE_N=1, SRAM_OE_N=1, rdata=0.
- WAIT_CYCLES=3, store ALU_result=1028, ST_val=0xDEADBEEF at t:
  - SRAM_ADDR=2 with DQ_out=0xBEEF for t+1..t+3, then SRAM_ADDR=3 with DQ_out=0xDEAD for t+4..t+6.
  - WE_N low at t+1,t+2,t+4,t+5; ready=1 at t+7; freeze=1 at t..t+6.
- Load from 1028 after that store, SRAM model returning stored data -> rdata=0xDEADBEEF at t+7, SRAM_DQ_oe=0 throughout.
- MEM_R_EN and MEM_W_EN both 1 -> write sequence executes. Dropping the enables at t+2 still completes the write, with ready at t+7.
- Assert rst at t+4 during a write -> WE_N=1, DQ_oe=0 immediately; state IDLE; the next load starts its sequence normally.
- SRAM_RD_BUF_EN defined, two loads from 1032 -> second returns same data with ready at t+1 and no OE_N assertion. An intervening store to 1032 of 0x12345678 makes the next load return 0x12345678 without an SRAM read.
